// File: rtl/ring_pos_from_remote_receiver_if.sv
// Bundles the incoming AXIS position beat and the outgoing per-particle
// stream towards the local position ring injection port.
interface ring_pos_from_remote_receiver_if #(
  parameter int OFFSET_WIDTH          = 29,
  parameter int ELEMENT_WIDTH         = 2,
  parameter int PARTICLE_ID_WIDTH     = 7,
  parameter int GLOBAL_CELL_ID_WIDTH  = 4,
  parameter int NB_CELL_COUNT_WIDTH   = 5,
  parameter int STREAMING_TDEST_WIDTH = 16,
  parameter int AXIS_TDATA_WIDTH      = 512
);
  localparam int PKT_W     = AXIS_TDATA_WIDTH + AXIS_TDATA_WIDTH/8 + STREAMING_TDEST_WIDTH + 2;
  localparam int OFF_PKT_W = 3*OFFSET_WIDTH + ELEMENT_WIDTH + PARTICLE_ID_WIDTH;

  logic [PKT_W-1:0]                  i_axis_pos_pkt_from_remote;
  logic                              o_axis_tready;
  logic [OFF_PKT_W-1:0]              o_offset_pkt;
  logic [3*GLOBAL_CELL_ID_WIDTH-1:0] o_gcid;
  logic [NB_CELL_COUNT_WIDTH-1:0]    o_lifetime;
  logic                              o_valid;
  logic                              i_ready;
  logic                              o_last;

  modport master (
    input  i_axis_pos_pkt_from_remote, i_ready,
    output o_axis_tready, o_offset_pkt, o_gcid, o_lifetime, o_valid, o_last
  );

  modport slave (
    output i_axis_pos_pkt_from_remote, i_ready,
    input  o_axis_tready, o_offset_pkt, o_gcid, o_lifetime, o_valid, o_last
  );
endinterface

// File: rtl/ring_pos_from_remote_receiver.sv
// Receives remote 512-bit position beats, filters on tdest, buffers two beats
// and unpacks valid sub-packets (slot 3 first) into a valid/ready particle stream.
module ring_pos_from_remote_receiver #(
  parameter int OFFSET_WIDTH          = 29,
  parameter int ELEMENT_WIDTH         = 2,
  parameter int PARTICLE_ID_WIDTH     = 7,
  parameter int GLOBAL_CELL_ID_WIDTH  = 4,
  parameter int NB_CELL_COUNT_WIDTH   = 5,
  parameter int NODE_ID_WIDTH         = 4,
  parameter int STREAMING_TDEST_WIDTH = 16,
  parameter int AXIS_TDATA_WIDTH      = 512,
  parameter int SUB_PACKET_WIDTH      = 128,
  parameter int NUM_SUB_PACKETS       = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NODE_ID_WIDTH-1:0] i_node_id,
  ring_pos_from_remote_receiver_if.master bus,
  output logic [15:0]              o_pos_received_cnt,
  output logic [7:0]               o_misroute_cnt,
  output logic                     o_overflow
);
  localparam int KEEP_W    = AXIS_TDATA_WIDTH/8;
  localparam int PKT_W     = AXIS_TDATA_WIDTH + KEEP_W + STREAMING_TDEST_WIDTH + 2;
  localparam int OFF_PKT_W = 3*OFFSET_WIDTH + ELEMENT_WIDTH + PARTICLE_ID_WIDTH;
  localparam int GCID_W    = 3*GLOBAL_CELL_ID_WIDTH;
  localparam int LT_LSB    = 97;
  localparam int GCID_LSB  = LT_LSB + NB_CELL_COUNT_WIDTH;
  localparam int EL_LSB    = GCID_LSB + GCID_W;
  localparam int PID_LSB   = EL_LSB + ELEMENT_WIDTH;
  localparam int SEL_W     = (NUM_SUB_PACKETS > 1) ? $clog2(NUM_SUB_PACKETS) : 1;

  typedef enum logic {IDLE, UNPACK} state_t;

  logic [PKT_W-1:0]                 pkt;
  logic [AXIS_TDATA_WIDTH-1:0]      tdata;
  logic [STREAMING_TDEST_WIDTH-1:0] tdest;
  logic                             tvalid, tready, accept, dest_ok, fifo_wr;
  logic                             unused_bits;

  assign pkt         = bus.i_axis_pos_pkt_from_remote;
  assign tdata       = pkt[AXIS_TDATA_WIDTH-1:0];
  assign tdest       = pkt[AXIS_TDATA_WIDTH+KEEP_W +: STREAMING_TDEST_WIDTH];
  assign tvalid      = pkt[PKT_W-1];
  assign unused_bits = ^pkt;

  logic                        ready_en_q;
  logic [AXIS_TDATA_WIDTH-1:0] fifo_q [2];
  logic                        wr_ptr_q, rd_ptr_q;
  logic [1:0]                  count_q;

  assign tready  = ready_en_q && (count_q != 2'd2);
  assign accept  = tvalid && tready;
  assign dest_ok = (tdest[NODE_ID_WIDTH-1:0] == i_node_id);
  assign fifo_wr = accept && dest_ok;
  assign bus.o_axis_tready = tready;

  state_t                      state_q, state_d;
  logic [AXIS_TDATA_WIDTH-1:0] beat_q, load_data;
  logic [NUM_SUB_PACKETS-1:0]  mask_q, mask_after, head_mask, load_mask;
  logic [SEL_W-1:0]            sel;
  logic [SUB_PACKET_WIDTH-1:0] slot;
  logic                        pop, load_beat, load_second, load_out, clr_valid, out_free;

  logic                        valid_q, last_q;
  logic [OFF_PKT_W-1:0]        offset_q;
  logic [GCID_W-1:0]           gcid_q;
  logic [NB_CELL_COUNT_WIDTH-1:0] lifetime_q;

  function automatic logic [NUM_SUB_PACKETS-1:0] slot_mask(input logic [AXIS_TDATA_WIDTH-1:0] d);
    logic [NUM_SUB_PACKETS-1:0] m;
    m = '0;
    for (int unsigned s = 0; s < NUM_SUB_PACKETS; s++)
      m[s] = |d[s*SUB_PACKET_WIDTH + LT_LSB +: NB_CELL_COUNT_WIDTH];
    return m;
  endfunction

  assign head_mask = slot_mask(fifo_q[rd_ptr_q]);
  assign load_data = load_second ? fifo_q[~rd_ptr_q] : fifo_q[rd_ptr_q];
  assign load_mask = slot_mask(load_data);
  assign out_free  = !valid_q || bus.i_ready;

  always_comb begin
    sel = '0;
    for (int unsigned s = 0; s < NUM_SUB_PACKETS; s++)
      if (mask_q[s]) sel = SEL_W'(s);
  end

  assign slot       = beat_q[sel*SUB_PACKET_WIDTH +: SUB_PACKET_WIDTH];
  assign mask_after = mask_q & ~(NUM_SUB_PACKETS'(1) << sel);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // The slot's mask bit is cleared when it moves into the output register, so
  // the beat can be popped and its successor loaded while the last particle
  // is still waiting for i_ready; this keeps back-to-back beats bubble-free.
  always_comb begin
    state_d     = state_q;
    pop         = 1'b0;
    load_beat   = 1'b0;
    load_second = 1'b0;
    load_out    = 1'b0;
    clr_valid   = 1'b0;
    case (state_q)
      IDLE: begin
        clr_valid = out_free;
        if (count_q != 2'd0) begin
          if (head_mask == '0) pop = 1'b1;
          else begin
            load_beat = 1'b1;
            state_d   = UNPACK;
          end
        end
      end
      UNPACK: begin
        if (mask_q == '0) begin
          clr_valid = out_free;
          pop       = 1'b1;
          if (count_q == 2'd2) begin
            load_beat   = 1'b1;
            load_second = 1'b1;
          end else state_d = IDLE;
        end else if (out_free) begin
          load_out = 1'b1;
          if (mask_after == '0) begin
            pop = 1'b1;
            if (count_q == 2'd2) begin
              load_beat   = 1'b1;
              load_second = 1'b1;
            end else state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (fifo_wr) fifo_q[wr_ptr_q] <= tdata;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ready_en_q     <= 1'b0;
      wr_ptr_q       <= 1'b0;
      rd_ptr_q       <= 1'b0;
      count_q        <= 2'd0;
      o_misroute_cnt <= '0;
      o_overflow     <= 1'b0;
    end else begin
      ready_en_q <= 1'b1;
      if (fifo_wr) wr_ptr_q <= ~wr_ptr_q;
      if (pop)     rd_ptr_q <= ~rd_ptr_q;
      count_q <= count_q + 2'(fifo_wr) - 2'(pop);
      if (accept && !dest_ok && (o_misroute_cnt != '1))
        o_misroute_cnt <= o_misroute_cnt + 8'd1;
      if (tvalid && !tready) o_overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      beat_q             <= '0;
      mask_q             <= '0;
      valid_q            <= 1'b0;
      last_q             <= 1'b0;
      offset_q           <= '0;
      gcid_q             <= '0;
      lifetime_q         <= '0;
      o_pos_received_cnt <= '0;
    end else begin
      if (load_beat) begin
        beat_q <= load_data;
        mask_q <= load_mask;
      end else if (load_out) begin
        mask_q <= mask_after;
      end
      if (load_out) begin
        valid_q    <= 1'b1;
        last_q     <= slot[96];
        offset_q   <= {slot[PID_LSB +: PARTICLE_ID_WIDTH], slot[EL_LSB +: ELEMENT_WIDTH],
                       slot[64 +: OFFSET_WIDTH], slot[32 +: OFFSET_WIDTH], slot[0 +: OFFSET_WIDTH]};
        gcid_q     <= slot[GCID_LSB +: GCID_W];
        lifetime_q <= slot[LT_LSB +: NB_CELL_COUNT_WIDTH];
      end else if (clr_valid) begin
        valid_q <= 1'b0;
      end
      if (valid_q && bus.i_ready) o_pos_received_cnt <= o_pos_received_cnt + 16'd1;
    end
  end

  assign bus.o_valid      = valid_q;
  assign bus.o_last       = last_q && valid_q;
  assign bus.o_offset_pkt = offset_q;
  assign bus.o_gcid       = gcid_q;
  assign bus.o_lifetime   = lifetime_q;
endmodule

// File: tb/tb_ring_pos_from_remote_receiver.sv
// Bench for ring_pos_from_remote_receiver: literal vectors, hand-written
// latency/backpressure/reset sequences and a randomized scoreboard run.
module tb_ring_pos_from_remote_receiver;
  typedef struct packed {
    logic [95:0] pkt;
    logic [11:0] gcid;
    logic [4:0]  lt;
    logic        last;
  } exp_t;

  typedef struct {
    logic [31:0] x, y, z;
    logic [6:0]  pid;
    logic [1:0]  el;
    logic [11:0] gcid;
    logic [4:0]  lt;
    logic        last;
    logic [95:0] exp_pkt;
    logic [11:0] exp_gcid;
    logic [4:0]  exp_lt;
    logic        exp_last;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  logic [3:0] node_id;
  logic [15:0] pos_cnt;
  logic [7:0]  mis_cnt;
  logic        ovf;

  ring_pos_from_remote_receiver_if bus ();

  ring_pos_from_remote_receiver dut (
    .clk                (clk),
    .rst                (rst),
    .i_node_id          (node_id),
    .bus                (bus),
    .o_pos_received_cnt (pos_cnt),
    .o_misroute_cnt     (mis_cnt),
    .o_overflow         (ovf)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  exp_t exp_q[$];
  logic [15:0] exp_cnt = '0;
  logic [7:0]  exp_mis = '0;
  logic        exp_ovf = 1'b0;
  logic        prev_hold = 1'b0;
  logic [113:0] prev_vals = '0;
  logic        want_ready = 1'b1;
  logic        rand_ready = 1'b0;
  vec_t        vecs [4];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [127:0] mk_sub(input logic [31:0] x, y, z, input logic last,
                                          input logic [4:0] lt, input logic [11:0] gcid,
                                          input logic [1:0] el, input logic [6:0] pid);
    return {5'b0, pid, el, gcid, lt, last, z, y, x};
  endfunction

  // Reference: each valid slot (nonzero lifetime), oldest slot first.
  function automatic void push_beat(input logic [511:0] d);
    logic [127:0] sub;
    exp_t e;
    for (int s = 3; s >= 0; s--) begin
      sub = d[s*128 +: 128];
      if (sub[101:97] != 5'd0) begin
        e.pkt  = {sub[122:116], sub[115:114], sub[92:64], sub[60:32], sub[28:0]};
        e.gcid = sub[113:102];
        e.lt   = sub[101:97];
        e.last = sub[96];
        exp_q.push_back(e);
      end
    end
  endfunction

  function automatic logic [113:0] out_vals();
    return {bus.o_offset_pkt, bus.o_gcid, bus.o_lifetime, bus.o_last};
  endfunction

  task automatic monitor();
    exp_t e;
    if (rst) begin
      if (prev_hold) chk("hold_stable", {bus.o_valid, out_vals()}, {1'b1, prev_vals});
      chk("pos_cnt", pos_cnt, exp_cnt);
      chk("misroute_cnt", mis_cnt, exp_mis);
      chk("overflow", ovf, exp_ovf);
      if (bus.o_valid && bus.i_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_particle actual=%0h required=none", out_vals());
        end else begin
          e = exp_q.pop_front();
          chk("particle", out_vals(), e);
        end
        exp_cnt++;
      end
      prev_hold = bus.o_valid && !bus.i_ready;
      prev_vals = out_vals();
    end
  endtask

  task automatic tick();
    @(negedge clk);
    bus.i_ready = rand_ready ? ($urandom_range(0, 3) != 0) : want_ready;
    bus.i_axis_pos_pkt_from_remote = '0;
    monitor();
  endtask

  task automatic send_now(input logic [511:0] d, input logic [15:0] dest,
                          input logic exp_acc, input logic do_chk);
    logic [63:0] keep;
    keep = {$urandom(), $urandom()};
    bus.i_axis_pos_pkt_from_remote = {1'b1, 1'($urandom()), dest, keep, d};
    if (do_chk) chk("tready", bus.o_axis_tready, exp_acc);
    if (exp_acc) begin
      if (dest[3:0] == node_id) push_beat(d);
      else if (exp_mis != 8'hFF) exp_mis++;
    end else exp_ovf = 1'b1;
  endtask

  task automatic send(input logic [511:0] d, input logic [15:0] dest, input logic exp_acc);
    tick();
    send_now(d, dest, exp_acc, 1'b1);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 400) begin
      tick();
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain_timeout actual=%0d required=0 pending", exp_q.size());
    end
    tick();
    tick();
  endtask

  function automatic logic [511:0] four_slot(input logic [31:0] x0);
    return {mk_sub(x0,     32'd0, 32'd0, 1'b0, 5'd1, 12'h0, 2'd0, 7'd0),
            mk_sub(x0 + 1, 32'd0, 32'd0, 1'b0, 5'd2, 12'h0, 2'd0, 7'd0),
            mk_sub(x0 + 2, 32'd0, 32'd0, 1'b0, 5'd3, 12'h0, 2'd0, 7'd0),
            mk_sub(x0 + 3, 32'd0, 32'd0, 1'b0, 5'd4, 12'h0, 2'd0, 7'd0)};
  endfunction

  initial begin
    logic [511:0] d;
    logic [127:0] sub [4];
    logic [15:0]  dest;
    logic [4:0]   lt;
    int n;

    vecs[0] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 7'h55, 2'd2, 12'hABC, 5'd27, 1'b0,
                {7'h55, 2'd2, 29'h1FFF_FFFF, 29'h1FFF_FFFF, 29'h1FFF_FFFF}, 12'hABC, 5'd27, 1'b0};
    vecs[1] = '{32'd5, 32'd6, 32'd7, 7'h01, 2'd0, 12'h001, 5'd1, 1'b1,
                {7'h01, 2'd0, 29'd7, 29'd6, 29'd5}, 12'h001, 5'd1, 1'b1};
    vecs[2] = '{32'hE000_0001, 32'h2000_0000, 32'h0123_4567, 7'h7F, 2'd3, 12'hFFF, 5'd31, 1'b0,
                {7'h7F, 2'd3, 29'h0123_4567, 29'h0, 29'h1}, 12'hFFF, 5'd31, 1'b0};
    vecs[3] = '{32'h1ABC_DEF0, 32'hFABC_DEF0, 32'd0, 7'h00, 2'd1, 12'h5A3, 5'd16, 1'b0,
                {7'h00, 2'd1, 29'h0, 29'h1ABC_DEF0, 29'h1ABC_DEF0}, 12'h5A3, 5'd16, 1'b0};

    rst = 1'b0;
    node_id = 4'h3;
    bus.i_ready = 1'b1;
    bus.i_axis_pos_pkt_from_remote = '0;
    tick();
    tick();
    chk("reset_outputs", {bus.o_axis_tready, bus.o_offset_pkt, bus.o_gcid, bus.o_lifetime,
                          bus.o_valid, bus.o_last, pos_cnt, mis_cnt, ovf}, '0);
    rst = 1'b1;
    tick();
    chk("tready_after_reset", bus.o_axis_tready, 1'b1);

    // Full beat: first output two cycles after acceptance, then one per cycle.
    send(four_slot(32'd5), {12'h0, node_id}, 1'b1);
    tick(); chk("latency_n1", bus.o_valid, 1'b0);
    tick(); chk("latency_n2", bus.o_valid, 1'b0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("full_beat_x", {bus.o_valid, bus.o_last, bus.o_offset_pkt[28:0]}, {1'b1, 1'b0, 29'(5 + i)});
    end
    tick(); chk("full_beat_end", bus.o_valid, 1'b0);
    chk("full_beat_cnt", pos_cnt, 16'd4);

    // Final partial beat: two padding slots skipped, last flag on slot 0.
    d = {128'd0, 128'd0,
         mk_sub(32'd9,  32'd0, 32'd0, 1'b0, 5'd3, 12'h0, 2'd0, 7'd0),
         mk_sub(32'd10, 32'd0, 32'd0, 1'b1, 5'd2, 12'h0, 2'd0, 7'd0)};
    send(d, {12'h0, node_id}, 1'b1);
    tick(); tick();
    tick(); chk("partial_first", {bus.o_valid, bus.o_last, bus.o_offset_pkt[28:0]}, {1'b1, 1'b0, 29'd9});
    tick(); chk("partial_last", {bus.o_valid, bus.o_last, bus.o_offset_pkt[28:0]}, {1'b1, 1'b1, 29'd10});
    tick(); chk("partial_end", bus.o_valid, 1'b0);

    for (int v = 0; v < 4; v++) begin
      d = {128'd0, mk_sub(vecs[v].x, vecs[v].y, vecs[v].z, vecs[v].last, vecs[v].lt,
                          vecs[v].gcid, vecs[v].el, vecs[v].pid), 128'd0, 128'd0};
      send(d, {12'hABC, node_id}, 1'b1);
      n = 0;
      while (!bus.o_valid && n < 10) begin
        tick();
        n++;
      end
      chk("vector_fields", {bus.o_valid, bus.o_offset_pkt, bus.o_gcid, bus.o_lifetime, bus.o_last},
          {1'b1, vecs[v].exp_pkt, vecs[v].exp_gcid, vecs[v].exp_lt, vecs[v].exp_last});
      drain();
    end

    // Backpressure: two beats buffered, a third is refused and flagged.
    send(four_slot(32'd100), {12'h0, node_id}, 1'b1);
    send(four_slot(32'd200), {12'h0, node_id}, 1'b1);
    tick();
    tick();
    want_ready = 1'b0;
    tick();
    tick();
    send(four_slot(32'd300), {12'h0, node_id}, 1'b0);
    tick();
    tick();
    want_ready = 1'b1;
    drain();
    chk("bp_overflow_sticky", ovf, 1'b1);

    send(four_slot(32'd400), {12'h0, node_id + 4'd1}, 1'b1);
    for (int i = 0; i < 6; i++) tick();
    chk("misroute_one", {bus.o_valid, mis_cnt}, {1'b0, 8'd1});

    rand_ready = 1'b1;
    for (int b = 0; b < 200; b++) begin
      for (int s = 0; s < 4; s++) begin
        lt = ($urandom_range(0, 9) < 3) ? 5'd0 : 5'($urandom_range(1, 31));
        sub[s] = mk_sub($urandom(), $urandom(), $urandom(), 1'($urandom()), lt,
                        12'($urandom()), 2'($urandom()), 7'($urandom()));
      end
      d = {sub[3], sub[2], sub[1], sub[0]};
      if ($urandom_range(0, 9) == 0) d = '0;
      dest = 16'($urandom());
      dest[3:0] = ($urandom_range(0, 9) == 0) ? (node_id ^ 4'($urandom_range(1, 15))) : node_id;
      n = 0;
      do begin
        tick();
        n++;
      end while (!bus.o_axis_tready && n < 100);
      if (!bus.o_axis_tready) begin
        checks++;
        failures++;
        $display("FAIL tready_timeout actual=0 required=1");
      end else send_now(d, dest, 1'b1, 1'b0);
      if ($urandom_range(0, 3) == 0) tick();
    end
    rand_ready = 1'b0;
    want_ready = 1'b1;
    drain();

    for (int i = 0; i < 260; i++) send('0, {12'h0, node_id ^ 4'h8}, 1'b1);
    tick();
    chk("misroute_saturate", mis_cnt, 8'hFF);

    // Asynchronous reset in the middle of unpacking.
    send(four_slot(32'd500), {12'h0, node_id}, 1'b1);
    tick(); tick(); tick();
    chk("pre_reset_valid", bus.o_valid, 1'b1);
    #2;
    rst = 1'b0;
    #1;
    chk("async_reset", {bus.o_axis_tready, bus.o_offset_pkt, bus.o_gcid, bus.o_lifetime,
                        bus.o_valid, bus.o_last, pos_cnt, mis_cnt, ovf}, '0);
    exp_q.delete();
    exp_cnt = '0;
    exp_mis = '0;
    exp_ovf = 1'b0;
    prev_hold = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    send(four_slot(32'd600), {12'h0, node_id}, 1'b1);
    tick(); tick();
    tick(); chk("post_reset_first", {bus.o_valid, bus.o_offset_pkt[28:0]}, {1'b1, 29'd600});
    drain();
    chk("post_reset_cnt", pos_cnt, 16'd4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/ring_pos_from_remote_receiver.md
# ring_pos_from_remote_receiver

Receive side of the inter-FPGA position stream. The block accepts 512-bit AXIS position beats arriving from a remote node and checks the destination. It unpacks each beat's four 128-bit sub-packets, oldest first, into per-particle offset packets with their global cell ID and lifetime, and presents them one per cycle, with a valid/ready handshake, to the local position ring injection port. It also detects the end-of-stream marker and counts received particles.

## Interface
Parameters:
- OFFSET_WIDTH, 29: width of one fixed-point offset coordinate.
- ELEMENT_WIDTH, 2: element-type field width.
- PARTICLE_ID_WIDTH, 7: particle ID width.
- GLOBAL_CELL_ID_WIDTH, 4: width of one cell coordinate; the gcid field is 3x this.
- NB_CELL_COUNT_WIDTH, 5: lifetime field width.
- NODE_ID_WIDTH, 4: node ID width.
- STREAMING_TDEST_WIDTH, 16: tdest width.
- AXIS_TDATA_WIDTH, 512: beat data width.
- SUB_PACKET_WIDTH, 128: sub-packet width.
- NUM_SUB_PACKETS, 4: sub-packets per beat.

Ports:
- clk  in  1  single clock for the whole block.
- rst  in  1  asynchronous, active-low reset.
- i_node_id  in  NODE_ID_WIDTH  this node's ID.
- i_axis_pos_pkt_from_remote  in  AXIS_PKT_STRUCT_WIDTH  packed beat, LSB to MSB:
  - tdata;
  - tkeep (AXIS_TDATA_WIDTH/8);
  - tdest (STREAMING_TDEST_WIDTH);
  - tlast (bit MSB-1);
  - tvalid (MSB).
- o_axis_tready  out  1  beat-buffer not full.
- o_offset_pkt  out  3*OFFSET_WIDTH+ELEMENT_WIDTH+PARTICLE_ID_WIDTH  packed as {pid, element, z, y, x}.
- o_gcid  out  3*GLOBAL_CELL_ID_WIDTH  global cell ID of the particle.
- o_lifetime  out  NB_CELL_COUNT_WIDTH  lifetime of the particle.
- o_valid  out  1  output sub-packet valid.
- i_ready  in  1  downstream accepts the output.
- o_last  out  1  qualifies o_valid; marks the final particle of the stream.
- o_pos_received_cnt  out  16  particles delivered since reset.
- o_misroute_cnt  out  8  beats dropped because of tdest mismatch.
- o_overflow  out  1  sticky flag: a beat arrived while tready was low.

## Operation
- Sub-packet layout, slot s = tdata[128s +: 128]:
  - [31:0] x, [63:32] y, [95:64] z; offset is the low OFFSET_WIDTH bits of each, and upper bits are ignored.
  - Bit 96: last flag.
  - Bits 97 upward, LSB first: lifetime, gcid, element, pid.
- Slot validity: a slot is valid iff its lifetime field != 0. Zero slots are padding and are never emitted.
- Order: slot 3 is the oldest and slot 0 the newest. Emission order is slot 3, 2, 1, 0, skipping invalid slots with no idle cycle.
- Accept rule: a beat is accepted when tvalid=1 and o_axis_tready=1.
  - tdest[NODE_ID_WIDTH-1:0] != i_node_id: the beat is dropped and o_misroute_cnt increments, saturating at 255.
  - Otherwise the beat is written to a 2-entry beat FIFO.
- Overflow: a beat with tvalid=1 while tready=0 is dropped and o_overflow is set. It clears only on reset.
- tkeep and tlast are ignored; every beat is single-transfer.
- Unpacker FSM:
  - IDLE, FIFO non-empty: load the head beat, compute the valid-slot mask, go to UNPACK.
  - IDLE, mask == 0: pop the beat and stay in IDLE.
  - UNPACK: present the highest remaining valid slot in the output register.
  - On o_valid & i_ready: clear that slot's mask bit and increment o_pos_received_cnt (wraps at 2^16).
  - When the mask empties: pop the FIFO. Load the next beat in the same cycle if one is present, else go to IDLE.
- o_last is 1 only when the presented slot has bit 96 = 1 (slot 0 of the final beat).

## Timing
- Reset values:
  - o_axis_tready = 0 during reset, 1 from the first cycle after release.
  - All other outputs = 0.
  - FIFO and mask are empty.
- Latency: a beat accepted at cycle N with the FIFO and unpacker idle gives its first o_valid at N+2 (FIFO write at N, load at N+1, output register at N+2).
- Throughput:
  - One particle per cycle while i_ready=1.
  - Back-to-back beats emit with no bubble.
  - A 4-valid-slot beat occupies 4 output cycles.
- Handshake: o_valid, o_offset_pkt, o_gcid, o_lifetime and o_last are held stable while o_valid & !i_ready.
- o_axis_tready = (FIFO count < 2). A simultaneous accept and pop with count=2 is not possible, because tready is already 0 then.
- Reset during UNPACK: everything clears immediately (asynchronous). Partial beats are discarded and counters return to 0.

## Test plan
- Full beat, i_ready=1: beat with slots 3..0 lifetimes 1,2,3,4, x=5,6,7,8 -> o_valid at N+2..N+5 with x=5,6,7,8 in that order; o_pos_received_cnt=4; o_last=0.
- Last partial beat: slots 3,2 zero, slot 1 lifetime 3, slot 0 lifetime 2 with bit 96=1 -> exactly 2 outputs on consecutive cycles; the second has o_last=1.
- Backpressure: i_ready=0 for 5 cycles mid-beat -> outputs held stable. A third beat arriving during this time sees tready=0 and sets o_overflow=1; the first two beats are still delivered intact.
- Misroute: tdest=i_node_id+1 -> no o_valid; o_misroute_cnt=1.
- Field extraction: pid=0x55, element=2, gcid=0xABC, lifetime=27, offsets of all ones -> each output field is bit-exact.
- Async reset asserted mid-UNPACK -> all outputs 0 in the same cycle; after release, a new beat is unpacked correctly starting from count 0.
